// File: rtl/y_mdu.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// followed by a registered sign-fix / special-case stage and a one-cycle done pulse.
module y_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return (~v) + W_ONE;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v);
        return (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_z;
    logic               r_dz;

    logic               w_accept;
    logic               w_sa_in;
    logic               w_sb_in;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_sub;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div_zero;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_z_res;
    logic               w_dz_res;

    assign busy = r_busy;
    assign done = r_done;
    assign z    = r_z;
    assign dz   = r_dz;

    assign w_accept = (r_state == S_IDLE) && start && !flush;

    // Operand signedness per funct3; magnitudes feed the unsigned datapath.
    always_comb begin
        w_sa_in = 1'b0;
        w_sb_in = 1'b0;
        case (funct3)
            3'b000, 3'b001: begin
                w_sa_in = a[WIDTH-1];
                w_sb_in = b[WIDTH-1];
            end
            3'b010: begin
                w_sa_in = a[WIDTH-1];
                w_sb_in = 1'b0;
            end
            3'b100, 3'b110: begin
                w_sa_in = a[WIDTH-1];
                w_sb_in = b[WIDTH-1];
            end
            default: begin
                w_sa_in = 1'b0;
                w_sb_in = 1'b0;
            end
        endcase
        if (w_sa_in) begin
            w_mag_a = f_neg(a);
        end else begin
            w_mag_a = a;
        end
        if (w_sb_in) begin
            w_mag_b = f_neg(b);
        end else begin
            w_mag_b = b;
        end
    end

    // One iteration step of both algorithms; the state register picks which one is kept.
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + ({1'b0, r_mcand} & {(WIDTH+1){r_lo[0]}});
        w_mul_hi  = w_mul_sum[WIDTH:1];
        w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        w_div_sh  = {r_hi, r_lo[WIDTH-1]};
        w_div_sub = w_div_sh - {1'b0, r_mcand};
        w_div_ge  = (w_div_sh >= {1'b0, r_mcand});
        if (w_div_ge) begin
            w_div_hi = w_div_sub[WIDTH-1:0];
        end else begin
            w_div_hi = w_div_sh[WIDTH-1:0];
        end
        w_div_lo = {r_lo[WIDTH-2:0], w_div_ge};
    end

    // Sign correction, hi/lo selection and divide special cases for the FIX stage.
    always_comb begin
        w_z_res    = '0;
        w_dz_res   = 1'b0;
        w_div_zero = (r_mcand == '0);
        w_ovf      = !r_op[0] && (r_a == W_MIN) && r_sb && (r_mcand == W_ONE);
        if (r_sa ^ r_sb) begin
            w_prod_s = f_neg2({r_hi, r_lo});
            w_quo    = f_neg(r_lo);
        end else begin
            w_prod_s = {r_hi, r_lo};
            w_quo    = r_lo;
        end
        if (r_sa) begin
            w_rem = f_neg(r_hi);
        end else begin
            w_rem = r_hi;
        end
        case (r_op)
            3'b000: w_z_res = w_prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_z_res = w_prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: begin
                if (w_div_zero) begin
                    w_z_res  = '1;
                    w_dz_res = 1'b1;
                end else if (w_ovf) begin
                    w_z_res = r_a;
                end else begin
                    w_z_res = w_quo;
                end
            end
            3'b110, 3'b111: begin
                if (w_div_zero) begin
                    w_z_res  = r_a;
                    w_dz_res = 1'b1;
                end else if (w_ovf) begin
                    w_z_res = '0;
                end else begin
                    w_z_res = w_rem;
                end
            end
            default: begin
                w_z_res  = '0;
                w_dz_res = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush aborts everything except IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_CALC;
                end
            end
            S_FIX: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch and iterative datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_op    <= 3'b000;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_a     <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= CNT_W'(WIDTH);
                        r_op    <= funct3;
                        r_sa    <= w_sa_in;
                        r_sb    <= w_sb_in;
                        r_a     <= a;
                        r_hi    <= '0;
                        if (funct3[2]) begin
                            r_mcand <= w_mag_b;
                            r_lo    <= w_mag_a;
                        end else begin
                            r_mcand <= w_mag_a;
                            r_lo    <= w_mag_b;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_op[2]) begin
                        r_hi <= w_div_hi;
                        r_lo <= w_div_lo;
                    end else begin
                        r_hi <= w_mul_hi;
                        r_lo <= w_mul_lo;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Registered handshake and result outputs; z/dz only change on a completed FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_z    <= '0;
            r_dz   <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
            if ((r_state == S_FIX) && !flush) begin
                r_z  <= w_z_res;
                r_dz <= w_dz_res;
            end
        end
    end

endmodule
